// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-bank geometry and the dump-reader state encoding.
package cpu_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks register addresses FIRST_REG..LAST_REG on a spare bank read port and
// streams each captured word out over a valid/ready handshake.
module reg_dump_reader
    import cpu_pkg::*;
#(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31,
    parameter int unsigned DW        = XLEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [REG_AW-1:0] rd_addr,
    input  logic [DW-1:0]     rd_data,
    output logic [DW-1:0]     out_data,
    output logic [REG_AW-1:0] out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [REG_AW-1:0] FIRST_A = REG_AW'(FIRST_REG);
    localparam logic [REG_AW-1:0] LAST_A  = REG_AW'(LAST_REG);

    dump_state_e       state_q, state_d;
    logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic [REG_AW-1:0] out_idx_q, out_idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rd_addr_q  <= FIRST_A;
            out_data_q <= '0;
            out_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
        end
    end

    // abort is checked first in every active state so it beats a handshake.
    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        case (state_q)
            IDLE: begin
                rd_addr_d = FIRST_A;
                if (start && !abort) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (abort) begin
                    state_d   = IDLE;
                    rd_addr_d = FIRST_A;
                end else begin
                    out_data_d = rd_data;
                    out_idx_d  = rd_addr_q;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (abort) begin
                    state_d   = IDLE;
                    rd_addr_d = FIRST_A;
                end else if (out_ready) begin
                    if (out_idx_q == LAST_A) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                        if (rd_addr_q < LAST_A) begin
                            rd_addr_d = rd_addr_q + REG_AW'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                rd_addr_d = FIRST_A;
            end
            default: begin
                state_d   = IDLE;
                rd_addr_d = FIRST_A;
            end
        endcase
    end

    assign rd_addr   = rd_addr_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_valid = (state_q == SEND);
    assign out_last  = (state_q == SEND) && (out_idx_q == LAST_A);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Self-checking bench for reg_dump_reader: a behavioural register bank and an
// in-order word scoreboard drive a full-range instance and a single-register instance.
module tb_reg_dump_reader;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, abort, out_ready;
    logic [4:0]  rd_addr, out_idx;
    logic [31:0] rd_data, out_data;
    logic        out_valid, out_last, busy, done;

    logic        s_start, s_abort, s_ready;
    logic [4:0]  s_rd_addr, s_out_idx;
    logic [31:0] s_rd_data, s_out_data;
    logic        s_out_valid, s_out_last, s_busy, s_done;

    // Behavioural bank: x0 reads as zero, writes are applied on falling edges.
    logic [31:0] bank [32];
    assign rd_data   = (rd_addr == 5'd0)   ? 32'd0 : bank[rd_addr];
    assign s_rd_data = (s_rd_addr == 5'd0) ? 32'd0 : bank[s_rd_addr];

    reg_dump_reader #(.FIRST_REG(0), .LAST_REG(31), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
    );

    reg_dump_reader #(.FIRST_REG(5), .LAST_REG(5), .DW(32)) dut_single (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
        .rd_addr(s_rd_addr), .rd_data(s_rd_data),
        .out_data(s_out_data), .out_idx(s_out_idx), .out_valid(s_out_valid),
        .out_ready(s_ready), .out_last(s_out_last), .busy(s_busy), .done(s_done)
    );

    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] ref_word(input int idx);
        return (idx == 0) ? 32'd0 : bank[idx];
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic preload_pattern();
        for (int i = 0; i < 32; i++) bank[i] = 32'hA5A5_0000 + 32'(i);
    endtask

    task automatic wait_valid_idx(input int idx, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (out_valid && out_idx == 5'(idx)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL wait_idx: got no valid idx %0d within 300 cycles, required it", idx);
        end
    endtask

    task automatic drain();
        bit idle_seen = 1'b0;
        out_ready = 1'b1;
        abort = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) begin
                idle_seen = 1'b1;
                break;
            end
            tick();
        end
        tests++;
        if (!idle_seen) begin
            fails++;
            $display("FAIL drain: busy=%0b after 300 cycles, required 0", busy);
        end
    endtask

    task automatic test_reset();
        tests++;
        if (rd_addr !== 5'd0 || out_data !== 32'd0 || out_idx !== 5'd0 || out_valid !== 1'b0 ||
            out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: addr=%0d data=%h idx=%0d v=%0b l=%0b b=%0b d=%0b, required all zero",
                     rd_addr, out_data, out_idx, out_valid, out_last, busy, done);
        end
        tests++;
        if (s_rd_addr !== 5'd5 || s_busy !== 1'b0 || s_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_single: addr=%0d busy=%0b v=%0b, required 5/0/0", s_rd_addr, s_busy, s_out_valid);
        end
        $display("[TB] reset state checked");
    endtask

    task automatic test_full_dump();
        int words = 0, dones = 0, done_c = -1, last_hs = -1;
        preload_pattern();
        out_ready = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            tick();
            start = 1'b0;
            if (out_valid) begin
                tests++;
                if (out_idx !== 5'(words) || out_data !== ref_word(words) || out_last !== (words == 31)) begin
                    fails++;
                    $display("FAIL full_word: idx=%0d data=%h last=%0b, required idx=%0d data=%h last=%0b",
                             out_idx, out_data, out_last, words, ref_word(words), words == 31);
                end
                $display("[TB] full dump word idx=%0d data=%h last=%0b cycle=%0d", out_idx, out_data, out_last, c);
                words++;
                last_hs = c;
            end
            if (done) begin
                dones++;
                done_c = c;
            end
        end
        tests++;
        if (words !== 32 || dones !== 1 || done_c !== 65 || last_hs !== 64 || busy !== 1'b0) begin
            fails++;
            $display("FAIL full_summary: words=%0d dones=%0d done_cycle=%0d last_hs=%0d busy=%0b, required 32/1/65/64/0",
                     words, dones, done_c, last_hs, busy);
        end
    endtask

    task automatic test_reset_mid_dump();
        bit ok;
        preload_pattern();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid_idx(3, ok);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (rd_addr !== 5'd0 || out_data !== 32'd0 || out_idx !== 5'd0 || out_valid !== 1'b0 ||
            out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: addr=%0d data=%h idx=%0d v=%0b b=%0b d=%0b, required all zero",
                     rd_addr, out_data, out_idx, out_valid, busy, done);
        end
        $display("[TB] async reset mid-dump checked");
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_backpressure();
        bit ok;
        preload_pattern();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid_idx(3, ok);
        tick();
        out_ready = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            tests++;
            if (out_valid !== 1'b1 || out_idx !== 5'd4 || out_data !== 32'hA5A5_0004) begin
                fails++;
                $display("FAIL stall_hold: v=%0b idx=%0d data=%h, required 1/4/a5a50004", out_valid, out_idx, out_data);
            end
            if (k == 1) bank[4] = 32'hDEAD_BEEF;
            if (k == 5) out_ready = 1'b1;
            else tick();
        end
        $display("[TB] backpressure word idx=4 accepted data=%h", out_data);
        tick();
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 5'd5 || out_data !== 32'hA5A5_0005) begin
            fails++;
            $display("FAIL after_stall: v=%0b idx=%0d data=%h, required 1/5/a5a50005", out_valid, out_idx, out_data);
        end
        drain();
    endtask

    task automatic test_write_during_read();
        bit ok;
        preload_pattern();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid_idx(6, ok);
        tick();
        bank[7] = 32'h1234_5678;
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 5'd7 || out_data !== 32'h1234_5678) begin
            fails++;
            $display("FAIL write_in_read: v=%0b idx=%0d data=%h, required 1/7/12345678", out_valid, out_idx, out_data);
        end
        $display("[TB] write-during-read word idx=%0d data=%h", out_idx, out_data);
        drain();
    endtask

    task automatic test_abort_restart();
        bit ok;
        int dones = 0;
        preload_pattern();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid_idx(10, ok);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_addr !== 5'd0) begin
            fails++;
            $display("FAIL abort: v=%0b busy=%0b done=%0b addr=%0d, required 0/0/0/0", out_valid, busy, done, rd_addr);
        end
        for (int i = 0; i < 4; i++) begin
            if (done) dones++;
            tick();
        end
        tests++;
        if (dones != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: dones=%0d busy=%0b, required 0/0", dones, busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 5'd0 || out_data !== 32'd0) begin
            fails++;
            $display("FAIL restart: v=%0b idx=%0d data=%h, required 1/0/0", out_valid, out_idx, out_data);
        end
        $display("[TB] abort at idx 10 then restart from idx=%0d", out_idx);
        drain();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL start_abort_idle: busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_start_busy();
        bit ok;
        preload_pattern();
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid_idx(2, ok);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_idx !== 5'd3 || out_data !== 32'hA5A5_0003) begin
            fails++;
            $display("FAIL start_busy: v=%0b idx=%0d data=%h, required 1/3/a5a50003", out_valid, out_idx, out_data);
        end
        $display("[TB] start while busy, next word idx=%0d", out_idx);
        drain();
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            int exp_idx = 0, dones = 0;
            bit expect_done = 1'b0;
            for (int i = 0; i < 32; i++) bank[i] = $urandom;
            start = 1'b1;
            out_ready = 1'b0;
            tick();
            start = 1'b0;
            for (int c = 0; c < 1000 && !(dones > 0 && !busy); c++) begin
                if (expect_done) begin
                    tests++;
                    if (done !== 1'b1) begin
                        fails++;
                        $display("FAIL rand_done: done=%0b after last handshake, required 1", done);
                    end
                    dones++;
                    expect_done = 1'b0;
                end else if (done) begin
                    tests++;
                    fails++;
                    $display("FAIL rand_spurious_done: done=1 at word %0d, required 0", exp_idx);
                end
                out_ready = ($urandom_range(0, 2) != 0);
                if (out_valid && out_ready) begin
                    tests++;
                    if (out_idx !== 5'(exp_idx) || out_data !== ref_word(exp_idx) || out_last !== (exp_idx == 31)) begin
                        fails++;
                        $display("FAIL rand_word: idx=%0d data=%h last=%0b, required idx=%0d data=%h last=%0b",
                                 out_idx, out_data, out_last, exp_idx, ref_word(exp_idx), exp_idx == 31);
                    end
                    if (exp_idx == 31) expect_done = 1'b1;
                    exp_idx++;
                end
                tick();
            end
            tests++;
            if (exp_idx != 32 || dones != 1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL rand_summary: words=%0d dones=%0d busy=%0b, required 32/1/0", exp_idx, dones, busy);
            end
            $display("[TB] random dump %0d: %0d words accepted", it, exp_idx);
        end
        drain();
    endtask

    task automatic test_single();
        int words = 0, dones = 0, done_c = -1, word_c = -1;
        preload_pattern();
        s_ready = 1'b1;
        s_start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            s_start = 1'b0;
            if (s_out_valid) begin
                words++;
                word_c = c;
                tests++;
                if (s_out_idx !== 5'd5 || s_out_data !== 32'hA5A5_0005 || s_out_last !== 1'b1) begin
                    fails++;
                    $display("FAIL single_word: idx=%0d data=%h last=%0b, required 5/a5a50005/1",
                             s_out_idx, s_out_data, s_out_last);
                end
            end
            if (s_done) begin
                dones++;
                done_c = c;
            end
        end
        tests++;
        if (words != 1 || dones != 1 || done_c != word_c + 1 || s_busy !== 1'b0) begin
            fails++;
            $display("FAIL single_summary: words=%0d dones=%0d word_c=%0d done_c=%0d busy=%0b, required 1/1/done one after word/0",
                     words, dones, word_c, done_c, s_busy);
        end
        $display("[TB] single-register dump: %0d word(s)", words);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        s_start = 1'b0;
        s_abort = 1'b0;
        s_ready = 1'b0;
        preload_pattern();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_full_dump();
        test_reset_mid_dump();
        test_backpressure();
        test_write_during_read();
        test_abort_restart();
        test_start_busy();
        test_random();
        test_single();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
